// File: rtl/mem_dual_port.sv
// Dual-port byte-enable RAM: write-first, cross-port forwarding, 1- or 2-cycle read.
// Optional per-byte even parity with a_perr/b_perr outputs when MEM_PARITY_EN is defined.
module mem_dual_port #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 49152,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                b_req,
  input  logic                a_we,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                a_rvalid,
  output logic                b_rvalid,
  output logic                a_err,
  output logic                b_err,
  output logic                collision
`ifdef MEM_PARITY_EN
  ,
  output logic                a_perr,
  output logic                b_perr
`endif
);
  localparam int NB = DATA_W / 8;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  // Index 0 is port A, index 1 is port B.
  logic [1:0]              req_w, we_w, in_rng, acc, wr;
  logic [1:0][NB-1:0]      be_w;
  logic [1:0][ADDR_W-1:0]  addr_w;
  logic [1:0][DATA_W-1:0]  wdata_w;
  logic [1:0][DATA_W-1:0]  raw_rd;

  assign req_w   = {b_req, a_req};
  assign we_w    = {b_we, a_we};
  assign be_w    = {b_be, a_be};
  assign addr_w  = {b_addr, a_addr};
  assign wdata_w = {b_wdata, a_wdata};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign in_rng[gi] = 32'(addr_w[gi]) < DEPTH_U;
    assign acc[gi]    = req_w[gi] && !rst;
    assign wr[gi]     = acc[gi] && we_w[gi] && in_rng[gi];
  end

`ifdef MEM_PARITY_EN
  logic [1:0][NB-1:0] par_raw;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    byte_par = '0;
    for (int i = 0; i < NB; i++) byte_par[i] = ^w[8*i +: 8];
  endfunction
`endif

  // One RAM per byte lane; B is written before A so A owns overlapping bytes.
  // The registered read returns the pre-write word; forwarding is merged later.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_a_q, rd_b_q;
    always_ff @(posedge clk) begin
      if (wr[1] && be_w[1][gi]) lane_mem[addr_w[1]] <= wdata_w[1][8*gi +: 8];
      if (wr[0] && be_w[0][gi]) lane_mem[addr_w[0]] <= wdata_w[0][8*gi +: 8];
      if (acc[0] && in_rng[0]) rd_a_q <= lane_mem[addr_w[0]];
      if (acc[1] && in_rng[1]) rd_b_q <= lane_mem[addr_w[1]];
    end
    assign raw_rd[0][8*gi +: 8] = rd_a_q;
    assign raw_rd[1][8*gi +: 8] = rd_b_q;
`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_a_q, par_b_q;
    always_ff @(posedge clk) begin
      if (wr[1] && be_w[1][gi]) par_mem[addr_w[1]] <= ^wdata_w[1][8*gi +: 8];
      if (wr[0] && be_w[0][gi]) par_mem[addr_w[0]] <= ^wdata_w[0][8*gi +: 8];
      if (acc[0] && in_rng[0]) par_a_q <= par_mem[addr_w[0]];
      if (acc[1] && in_rng[1]) par_b_q <= par_mem[addr_w[1]];
    end
    assign par_raw[0][gi] = par_a_q;
    assign par_raw[1][gi] = par_b_q;
`endif
  end

  // Per reading port: which bytes each writer put on the same address this access.
  logic [1:0][1:0][NB-1:0]     wen1_q;
  logic [1:0][1:0][DATA_W-1:0] wd1_q;
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        for (int q = 0; q < 2; q++) begin
          wen1_q[p][q] <= (wr[q] && addr_w[q] == addr_w[p]) ? be_w[q] : '0;
          wd1_q[p][q]  <= wdata_w[q];
        end
      end
    end
  end

  logic [1:0] v1_q, e1_q, ok1_q;
  logic       col1_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= '0;
      e1_q   <= '0;
      ok1_q  <= '0;
      col1_q <= 1'b0;
    end else begin
      col1_q <= wr[0] && wr[1] && (addr_w[0] == addr_w[1]);
      for (int p = 0; p < 2; p++) begin
        v1_q[p] <= acc[p];
        e1_q[p] <= acc[p] && !in_rng[p];
        if (acc[p]) ok1_q[p] <= in_rng[p];
      end
    end
  end

  logic [1:0][DATA_W-1:0] merged;
`ifdef MEM_PARITY_EN
  logic [1:0] perr1;
`endif
  always_comb begin
    merged = '0;
`ifdef MEM_PARITY_EN
    perr1 = '0;
`endif
    for (int p = 0; p < 2; p++) begin
      merged[p] = raw_rd[p];
      for (int q = 1; q >= 0; q--) begin
        for (int i = 0; i < NB; i++) begin
          if (wen1_q[p][q][i]) merged[p][8*i +: 8] = wd1_q[p][q][8*i +: 8];
        end
      end
      if (!ok1_q[p]) merged[p] = '0;
`ifdef MEM_PARITY_EN
      // Freshly written bytes carry freshly generated parity, so only stored bytes are checked.
      perr1[p] = v1_q[p] && ok1_q[p] &&
                 |(~(wen1_q[p][0] | wen1_q[p][1]) & (par_raw[p] ^ byte_par(raw_rd[p])));
`endif
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [1:0]             v2_q, e2_q;
    logic                   col2_q;
    logic [1:0][DATA_W-1:0] d2_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q   <= '0;
        e2_q   <= '0;
        col2_q <= 1'b0;
        d2_q   <= '0;
      end else begin
        v2_q   <= v1_q;
        e2_q   <= e1_q;
        col2_q <= col1_q;
        for (int p = 0; p < 2; p++) begin
          if (v1_q[p]) d2_q[p] <= merged[p];
        end
      end
    end
    assign a_rdata   = d2_q[0];
    assign b_rdata   = d2_q[1];
    assign a_rvalid  = v2_q[0];
    assign b_rvalid  = v2_q[1];
    assign a_err     = e2_q[0];
    assign b_err     = e2_q[1];
    assign collision = col2_q;
`ifdef MEM_PARITY_EN
    logic [1:0] perr2_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) perr2_q <= '0;
      else     perr2_q <= perr1;
    end
    assign a_perr = perr2_q[0];
    assign b_perr = perr2_q[1];
`endif
  end else begin : g_lat1
    assign a_rdata   = merged[0];
    assign b_rdata   = merged[1];
    assign a_rvalid  = v1_q[0];
    assign b_rvalid  = v1_q[1];
    assign a_err     = e1_q[0];
    assign b_err     = e1_q[1];
    assign collision = col1_q;
`ifdef MEM_PARITY_EN
    assign a_perr = perr1[0];
    assign b_perr = perr1[1];
`endif
  end
endmodule

// File: doc/mem_dual_port.md
MEM_DUAL_PORT -- requirements
Module: mem_dual_port

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, data word width in bits; it shall be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 49152, number of words.
REQ-003 The block SHALL have parameter ADDR_W, default 16, address width; it shall satisfy 2^ADDR_W >= DEPTH.
REQ-004 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the ports a_req and b_req, input, 1 bit each: per-port access request, one access per cycle.
REQ-008 The block SHALL have the ports a_we and b_we, input, 1 bit each: 1 = write, 0 = read; qualified by req.
REQ-009 The block SHALL have the ports a_be and b_be, input, DATA_W/8 bits each: byte write enables; bit i covers data[8i+7:8i].
REQ-010 The block SHALL have the ports a_addr and b_addr, input, ADDR_W bits each: word address.
REQ-011 The block SHALL have the ports a_wdata and b_wdata, input, DATA_W bits each: write data.
REQ-012 The block SHALL have the ports a_rdata and b_rdata, output, DATA_W bits each: read data.
REQ-013 The block SHALL have the ports a_rvalid and b_rvalid, output, 1 bit each: rdata valid strobe.
REQ-014 The block SHALL have the ports a_err and b_err, output, 1 bit each: out-of-range access strobe.
REQ-015 The block SHALL have the port collision, output, 1 bit: same-cycle dual write to one address.

Function
REQ-016 The block SHALL store data only when req=1, we=1 and addr<DEPTH; only the bytes selected by be shall change.
REQ-017 On a write, the block SHALL return the merged post-write word on rdata with rvalid after RD_LAT cycles (write-first).
REQ-018 On a read (req=1, we=0, addr<DEPTH), the block SHALL drive rdata with the word and rvalid=1 for exactly one cycle, RD_LAT cycles after the request edge.
REQ-019 When both ports write the same address in one cycle, the block SHALL apply port B's enabled bytes first and then port A's, so port A wins overlapping bytes.
REQ-020 In the case of REQ-019, the block SHALL pulse collision for one cycle, aligned with rvalid.
REQ-021 When one port reads an address that the other port writes in the same cycle, the block SHALL return the post-write word (cross-port forwarding).
REQ-022 When addr>=DEPTH, the block SHALL ignore the write, return rdata=0 and pulse both rvalid and err, aligned as in REQ-018.
REQ-023 When rvalid=0, the block SHALL hold rdata at its last value.
REQ-024 When RD_LAT=2, the block SHALL use one extra output register stage and keep full throughput of one access per port per cycle.
REQ-025 The block SHALL keep the two ports independent; concurrent reads of the same address shall both return identical data.

Reset
REQ-026 While rst=1, the block SHALL immediately force rdata, rvalid, err, collision and every pipeline valid bit to 0, and shall ignore any request.
REQ-027 Reset SHALL NOT clear memory contents, and a write in flight when reset asserts may or may not complete.
REQ-028 After rst deasserts, the block SHALL accept a request on the first clk edge.

Configuration
REQ-029 With macro MEM_PARITY_EN defined, the block SHALL store one even-parity bit per byte, generated on write.
REQ-030 With MEM_PARITY_EN defined, the block SHALL check parity on every read and add outputs a_perr and b_perr (1 bit each, out-of-range accesses excluded).
REQ-031 With MEM_PARITY_EN defined, a_perr and b_perr SHALL pulse with rvalid when any byte mismatches, and shall reset to 0.
REQ-032 Without MEM_PARITY_EN, the block SHALL have no parity storage and no perr ports.

Verification
REQ-033 The bench SHALL cover: RD_LAT=1, A writes 0x1122334455667788 to addr 5 with be=0xFF, then reads addr 5 -> a_rdata=0x1122334455667788 with a_rvalid one cycle after each request.
REQ-034 The bench SHALL cover: a partial write of 0xFFFFFFFFFFFFFFFF to addr 5 with be=0x0F, then a read -> 0x11223344FFFFFFFF.
REQ-035 The bench SHALL cover: same cycle, A writes 0xAAAA..AA be=0xFF and B writes 0xBBBB..BB be=0xFF to addr 9 -> collision=1 for one cycle, and a later read of addr 9 returns 0xAAAA..AA.
REQ-036 The bench SHALL cover: A writes 0x0123456789ABCDEF to addr 3 while B reads addr 3 in the same cycle -> b_rdata=0x0123456789ABCDEF.
REQ-037 The bench SHALL cover: RD_LAT=2 with B reading addr DEPTH -> b_rdata=0 and b_rvalid=b_err=1 two cycles after the request, and memory unchanged.
REQ-038 The bench SHALL cover: rst asserted mid-stream with back-to-back reads pending -> all valid/err outputs go 0 without waiting for a clock edge, and no rvalid appears after release until a new request.
